// File: rtl/jtframe_sdm_dac.sv
// jtframe_sdm_dac: second-order sigma-delta 1-bit audio DAC with input resync and internal step enable.
// Define JTFRAME_SDM_DITHER_EN to add LFSR dither into the second integrator.
module jtframe_sdm_dac #(
  parameter int DIV       = 4,
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic        clk_dac,
  input  logic        rst,
  input  logic [15:0] snd_in,
  output logic        dac_out,
  output logic        cen_out,
  output logic        ovf
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  logic [CW-1:0] cnt;
  logic [15:0] s1, s2, s_stable, u;
  logic [19:0] acc1, a1_s;
  logic [23:0] acc2, a2_s;
  logic [21:0] a1_w, fb;
  logic [25:0] a2_w, d;
  logic c1, c2;
  always_comb begin
    fb   = dac_out ? 22'h10000 : 22'h0;
    a1_w = {{2{acc1[19]}}, acc1} + {6'd0, u} - fb;
    c1   = a1_w[21:19] != {3{a1_w[21]}};
    a1_s = c1 ? {a1_w[21], {19{~a1_w[21]}}} : a1_w[19:0];
    a2_w = {{2{acc2[23]}}, acc2} + {{6{a1_s[19]}}, a1_s} - {4'd0, fb} + d;
    c2   = a2_w[25:23] != {3{a2_w[25]}};
    a2_s = c2 ? {a2_w[25], {23{~a2_w[25]}}} : a2_w[23:0];
  end
`ifdef JTFRAME_SDM_DITHER_EN
  logic [15:0] lfsr;
  assign d = {22'd0, lfsr[3:0]} - 26'd8;
  always_ff @(posedge clk_dac or posedge rst)
    if (rst) lfsr <= 16'hACE1;
    else if (cen_out) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`else
  assign d = '0;
`endif
  always_ff @(posedge clk_dac or posedge rst)
    if (rst) begin
      cnt      <= '0;
      cen_out  <= 1'b0;
      s1       <= '0;
      s2       <= '0;
      s_stable <= '0;
      u        <= '0;
      acc1     <= '0;
      acc2     <= '0;
      dac_out  <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      cnt     <= cnt == LAST ? '0 : cnt + 1'b1;
      cen_out <= cnt == LAST;
      s1      <= snd_in;
      s2      <= s1;
      // only accept a word that held across two samples, so no half-settled bits leak through
      if (s1 == s2) s_stable <= s2;
      if (cen_out) begin
        u       <= s_stable ^ {SIGNED_IN, 15'b0};
        acc1    <= a1_s;
        acc2    <= a2_s;
        dac_out <= ~a2_s[23] & (|a2_s);
        ovf     <= ovf | c1 | c2;
      end
    end
endmodule

// File: tb/tb_jtframe_sdm_dac.sv
// tb_jtframe_sdm_dac: scoreboard bench for the sigma-delta DAC against an integer reference model.
module tb_jtframe_sdm_dac;
  localparam int DIV = 4;
  logic clk_dac = 1'b0, rst = 1'b1;
  logic [15:0] snd_in = 16'h0;
  logic dac_out, cen_out, ovf;
  typedef struct { logic dac; logic ov; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, ones = 0, gap = 0;
  int m_acc1, m_acc2, m_u;
  logic m_dac, m_ovf;
  logic [15:0] m_lfsr;
  bit active = 0, was_cen = 0;

  always #5 clk_dac = ~clk_dac;

  jtframe_sdm_dac #(.DIV(DIV), .SIGNED_IN(1'b1)) dut (
    .clk_dac(clk_dac),
    .rst(rst),
    .snd_in(snd_in),
    .dac_out(dac_out),
    .cen_out(cen_out),
    .ovf(ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_acc1 = 0; m_acc2 = 0; m_u = 0; m_dac = 1'b0; m_ovf = 1'b0; m_lfsr = 16'hACE1;
    q.delete();
  endtask

  task automatic model_step(input logic [15:0] x);
    int fb, d, a1, a2;
    exp_t e;
    fb = m_dac ? 65536 : 0;
    d = 0;
`ifdef JTFRAME_SDM_DITHER_EN
    d = int'(m_lfsr[3:0]) - 8;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
    a1 = m_acc1 + m_u - fb;
    if (a1 > 524287) begin a1 = 524287; m_ovf = 1'b1; end
    else if (a1 < -524288) begin a1 = -524288; m_ovf = 1'b1; end
    a2 = m_acc2 + a1 + d - fb;
    if (a2 > 8388607) begin a2 = 8388607; m_ovf = 1'b1; end
    else if (a2 < -8388608) begin a2 = -8388608; m_ovf = 1'b1; end
    m_acc1 = a1;
    m_acc2 = a2;
    m_dac = a2 > 0;
    m_u = int'($signed(x)) + 32768;
    e.dac = m_dac;
    e.ov = m_ovf;
    q.push_back(e);
  endtask

  // monitor: cen spacing, and the modulator result one cycle after each step strobe
  always @(negedge clk_dac) begin
    if (rst) gap = 0;
    else begin
      gap++;
      if (cen_out) begin
        chk("cen_period", gap, DIV);
        gap = 0;
      end
    end
    if (was_cen) begin
      if (q.size() == 0) chk("queue_underflow", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("dac_out", dac_out, e.dac);
        chk("ovf", ovf, e.ov);
        ones += int'(dac_out);
      end
    end
    was_cen = cen_out && active && !rst;
  end

  task automatic do_reset(input logic [15:0] x);
    @(posedge clk_dac);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_dac", dac_out, 0);
    chk("rst_async_cen", cen_out, 0);
    chk("rst_async_ovf", ovf, 0);
    snd_in = x;
    model_reset();
    repeat (3) begin
      @(negedge clk_dac);
      chk("rst_hold_dac", dac_out, 0);
      chk("rst_hold_cen", cen_out, 0);
      chk("rst_hold_ovf", ovf, 0);
    end
    #2 rst = 1'b0;
`ifdef JTFRAME_SDM_DITHER_EN
    #1 chk("lfsr_seed", dut.lfsr, 16'hACE1);
`endif
  endtask

  task automatic wait_cen(output int n);
    n = 0;
    do begin
      @(negedge clk_dac);
      n++;
    end while (!cen_out && n < 4 * DIV);
    if (!cen_out) chk("cen_timeout", 0, 1);
  endtask

  task automatic run_phase(input logic [15:0] x0, input int n, input bit rnd);
    int w, hold;
    do_reset(x0);
    active = 1;
    ones = 0;
    hold = 2;
    for (int k = 0; k < n; k++) begin
      wait_cen(w);
      if (k == 0) chk("first_cen", w, DIV);
      model_step(snd_in);
      if (rnd) begin
        hold--;
        if (hold == 0) begin
          snd_in = 16'($urandom);
          hold = $urandom_range(2, 5);
        end
      end
    end
    repeat (2) @(negedge clk_dac);
    active = 0;
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    bit found;
    repeat (2) @(negedge clk_dac);
    chk("init_dac", dac_out, 0);
    chk("init_cen", cen_out, 0);
    chk("init_ovf", ovf, 0);
    run_phase(16'h8000, 1024, 0);
`ifdef JTFRAME_SDM_DITHER_EN
    chk("u0_ones_le1pct", ones <= 10, 1);
`else
    chk("u0_ones", ones, 0);
    chk("u0_ovf", ovf, 0);
`endif
    run_phase(16'h0000, 1024, 0);
    chk("mid_ones", ones >= 510 && ones <= 514, 1);
    run_phase(16'hC000, 4096, 0);
    chk("quarter_ones", ones >= 1020 && ones <= 1028, 1);
    run_phase(16'h7FFF, 2048, 0);
    chk("full_ones", ones >= 2048 - 3, 1);
    chk("full_ovf", ovf, m_ovf);
    run_phase(16'($urandom), 4096, 1);
    do_reset(16'h00FF);
    repeat (4) @(negedge clk_dac);
    chk("s_stable_load", dut.s_stable, 16'h00FF);
    for (int i = 0; i < 64; i++) begin
      snd_in = i[0] ? 16'h00FF : 16'hFF00;
      @(negedge clk_dac);
      chk("s_stable_hold", dut.s_stable, 16'h00FF);
    end
    snd_in = 16'h1234;
    found = 0;
    for (int i = 0; i < 3 + DIV + 1 && !found; i++) begin
      @(negedge clk_dac);
      found = dut.u == 16'h9234;
    end
    chk("u_latency", found, 1);
    do_reset(16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
